mul_share_sched: RTL and testbench



---
 rtl/mul_share_sched.sv | 182 ++++++++++++++++++
 tb/tb_mul_share_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_sched
//  Purpose  : One iterative shift-and-add WIDTH x WIDTH multiplier shared by
//             NUM_REQ requesters through a round-robin valid/ready front end.
//             Returns the truncated product, an overflow flag and the issuing
//             requester id on one valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_share_sched #(
  parameter int WIDTH   = 5,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_out,
  output logic                     resp_overflow,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [ID_W-1:0]  GRANT_TOP = ID_W'(NUM_REQ - 1);

  // Registered state
  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   resp_out_q, resp_out_d;
  logic               resp_ovf_q, resp_ovf_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;

  // Combinational helpers
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               accept;
  logic [2*WIDTH-1:0] acc_sum;

  // Round-robin search starting just after the previous grant, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == GRANT_TOP) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // A request is taken whenever the engine is idle and someone is granted
  assign accept = (state_q == S_IDLE) && grant_found;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one partial product per CALC cycle, result latch
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    resp_out_d   = resp_out_q;
    resp_ovf_d   = resp_ovf_q;
    resp_id_d    = resp_id_q;
    acc_sum      = acc_q + (b_q[0] ? a_q : {2*WIDTH{1'b0}});
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = {{WIDTH{1'b0}}, sel_a};
          b_d          = sel_b;
          acc_d        = '0;
          cnt_d        = '0;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
        end
      end
      S_CALC: begin
        // Fixed latency: all WIDTH steps run even once b has drained to zero
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          resp_out_d = acc_sum[WIDTH-1:0];
          resp_ovf_d = |acc_sum[2*WIDTH-1:WIDTH];
          resp_id_d  = id_q;
        end
      end
      default: ;
    endcase
  end

  // State register; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      last_grant_q <= GRANT_TOP;
      resp_out_q   <= '0;
      resp_ovf_q   <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      resp_out_q   <= resp_out_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Output decode; req_ready only ever asserts for the granted requester while idle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    resp_valid = (state_q == S_DONE);
    busy       = (state_q == S_CALC) || (state_q == S_DONE);
  end

  assign resp_out      = resp_out_q;
  assign resp_overflow = resp_ovf_q;
  assign resp_id       = resp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_share_sched
//  Purpose  : Directed, table-driven bench for mul_share_sched
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_sched;

  localparam int W  = 5;
  localparam int N  = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_out;
  logic              resp_overflow;
  logic [IW-1:0]     resp_id;
  logic              busy;

  mul_share_sched #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_out      (resp_out),
    .resp_overflow (resp_overflow),
    .resp_id       (resp_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int a;
    int b;
    int out;
    int ovf;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One request/response transaction. Called just after a negedge with the
  // request inputs already applied; returns in the idle cycle after the response.
  task automatic txn(input int exp_id, input int exp_out, input int exp_ovf,
                     input logic [N-1:0] v_after, input logic [N*W-1:0] a_after,
                     input logic [N*W-1:0] b_after, input int hold, output int waited);
    int k;
    logic [W-1:0]  o0;
    logic [IW-1:0] i0;
    resp_ready = (hold == 0);
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 12) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("grant", int'(req_ready), 1 << exp_id);
    if (req_ready == '0) return;
    @(negedge clk); #1;
    req_valid = v_after;
    req_a     = a_after;
    req_b     = b_after;
    chk("ready_pulse", int'(req_ready), 0);
    chk("busy_calc", int'(busy), 1);
    k = 1;
    while (!resp_valid && k < 12) begin
      @(negedge clk); #1;
      k++;
    end
    chk("latency", k, W + 1);
    chk("resp_out", int'(resp_out), exp_out);
    chk("resp_ovf", int'(resp_overflow), exp_ovf);
    chk("resp_id", int'(resp_id), exp_id);
    o0 = resp_out;
    i0 = resp_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_out", int'(resp_out), int'(o0));
      chk("hold_id", int'(resp_id), int'(i0));
      chk("hold_ready", int'(req_ready), 0);
    end
    if (hold > 0) resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("resp_drop", int'(resp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [N*W-1:0] av, bv;

    tv[0] = '{0,  3,  7, 21, 0};
    tv[1] = '{1,  7,  5,  3, 1};
    tv[2] = '{1, 31, 31,  1, 1};
    tv[3] = '{1,  0, 31,  0, 0};
    tv[4] = '{0,  8,  4,  0, 1};
    tv[5] = '{0,  1,  1,  1, 0};
    tv[6] = '{2, 31,  1, 31, 0};
    tv[7] = '{2,  5,  6, 30, 0};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_out", int'(resp_out), 0);
    chk("rst_ovf", int'(resp_overflow), 0);
    chk("rst_id", int'(resp_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-requester vectors, each granted back-to-back
    for (int i = 0; i < 8; i++) begin
      av = '0;
      bv = '0;
      av[tv[i].id*W +: W] = W'(tv[i].a);
      bv[tv[i].id*W +: W] = W'(tv[i].b);
      req_valid = '0;
      req_valid[tv[i].id] = 1'b1;
      req_a = av;
      req_b = bv;
      txn(tv[i].id, tv[i].out, tv[i].ovf, '0, av, bv, 0, w);
      chk("vec_wait", w, 0);
    end

    // All requesters continuously valid: round-robin 0,1,2,0
    av = {5'd5, 5'd7, 5'd3};
    bv = {5'd6, 5'd5, 5'd7};
    req_a = av;
    req_b = bv;
    req_valid = 3'b111;
    txn(0, 21, 0, 3'b111, av, bv, 0, w);
    chk("rr_wait0", w, 0);
    txn(1, 3, 1, 3'b111, av, bv, 0, w);
    chk("rr_wait1", w, 0);
    txn(2, 30, 0, 3'b111, av, bv, 0, w);
    chk("rr_wait2", w, 0);
    txn(0, 21, 0, 3'b000, av, bv, 0, w);
    chk("rr_wait3", w, 0);

    // Response back-pressure for 4 cycles with requester 1 waiting
    req_valid = 3'b001;
    txn(0, 21, 0, 3'b010, av, bv, 4, w);
    txn(1, 3, 1, 3'b000, av, bv, 0, w);
    chk("bp_next_grant", w, 0);

    // Operands change the cycle after the handshake
    av = '0; bv = '0;
    av[2*W +: W] = 5'd2;
    bv[2*W +: W] = 5'd3;
    req_a = av;
    req_b = bv;
    req_valid = 3'b100;
    av[2*W +: W] = 5'd31;
    bv[2*W +: W] = 5'd31;
    txn(2, 6, 0, 3'b000, av, bv, 0, w);

    // Reset during CALC cycle 3
    av = {5'd0, 5'd7, 5'd3};
    bv = {5'd0, 5'd5, 5'd7};
    req_a = av;
    req_b = bv;
    req_valid = 3'b001;
    resp_ready = 1'b1;
    #1;
    chk("rstcalc_grant", int'(req_ready), 1);
    @(negedge clk);
    #1;
    req_valid = 3'b011;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(resp_valid), 0);
    chk("arst_out", int'(resp_out), 0);
    chk("arst_id", int'(resp_id), 0);
    @(negedge clk);
    #1;
    chk("arst_hold_valid", int'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 21, 0, 3'b010, av, bv, 0, w);
    chk("arst_regrant_wait", w, 0);
    txn(1, 3, 1, 3'b000, av, bv, 0, w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
